// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - 4:1 mux channel scanner packing sampled z into handshaked frames
module mux_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       z,
    output logic       s1,
    output logic       s0,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       overrun,
    input  logic       clr_ovr,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ch_q, ch_d;
    // Channel 3 is never stored: its sample goes straight into the frame.
    logic [2:0]    shadow_q, shadow_d;
    logic [3:0]    frame_q, frame_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          accept;
    logic          complete;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ch_q     <= 2'd0;
            shadow_q <= 3'd0;
            frame_q  <= 4'd0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state: scan stepping, frame hand-off and overrun tracking.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        complete = 1'b0;
        accept   = valid_q & frame_ready;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = SCAN;
                    cnt_d    = '0;
                    ch_d     = 2'd0;
                    shadow_d = 3'd0;
                end
            end
            SCAN: begin
                if (!en) begin
                    // Abort discards the partial sample set; next entry restarts at ch0.
                    state_d  = IDLE;
                    cnt_d    = '0;
                    ch_d     = 2'd0;
                    shadow_d = 3'd0;
                end else if (cnt_q == LAST) begin
                    cnt_d = '0;
                    ch_d  = ch_q + 2'd1;
                    case (ch_q)
                        2'd0:    shadow_d[0] = z;
                        2'd1:    shadow_d[1] = z;
                        2'd2:    shadow_d[2] = z;
                        default: complete    = 1'b1;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_ovr) begin
            ovr_d = 1'b0;
        end

        if (complete) begin
            if (!valid_q || accept) begin
                frame_d = {z, shadow_q};
                valid_d = 1'b1;
            end else begin
                // Pending frame wins; the new one is lost and flagged (beats clr_ovr).
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    assign s1          = ch_q[1];
    assign s0          = ch_q[0];
    assign frame       = frame_q;
    assign frame_valid = valid_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q == SCAN);

endmodule
